// File: rtl/ddr_arb_pkg.sv
// Shared types, AXI field widths and round-robin helpers for the DDR AXI arbiter.
package ddr_arb_pkg;
    localparam int NUM_M   = 2;
    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int LOCK_W  = 1;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int QOS_W   = 4;
    localparam int RESP_W  = 2;

    typedef logic mst_idx_t;

    // ptr names the master that wins a tie; a lone requester always wins
    function automatic mst_idx_t rr_pick(input mst_idx_t ptr, input logic req0, input logic req1);
        if (req0 && req1) return ptr;
        else if (req1)    return 1'b1;
        else              return 1'b0;
    endfunction

    function automatic mst_idx_t rr_next(input mst_idx_t granted);
        return ~granted;
    endfunction
endpackage

// File: rtl/axi_wr_order_fifo.sv
// Order FIFO of granted AW master indices; the head selects which master owns the W channel.
module axi_wr_order_fifo
    import ddr_arb_pkg::*;
#(
    parameter int WQ_DEPTH = 4
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     push,
    input  mst_idx_t push_idx,
    input  logic     pop,
    output mst_idx_t head_idx,
    output logic     full,
    output logic     empty
);
    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WQ_DEPTH-1:0] mem;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                push_ok;
    logic                pop_ok;

    assign full     = (count == CNT_W'(WQ_DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_idx = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_idx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ddr_axi_arbiter.sv
// Two-master to one-slave AXI4 arbiter for the DDR4 port: round-robin AR/AW, ID-tagged R/B return,
// W steered in AW grant order.
module ddr_axi_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 34,
    parameter int DATA_W   = 64,
    parameter int WQ_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    // master 0
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ID_W-1:0]     m0_arid,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [LEN_W-1:0]    m0_arlen,
    input  logic [SIZE_W-1:0]   m0_arsize,
    input  logic [BURST_W-1:0]  m0_arburst,
    input  logic [LOCK_W-1:0]   m0_arlock,
    input  logic [CACHE_W-1:0]  m0_arcache,
    input  logic [PROT_W-1:0]   m0_arprot,
    input  logic [QOS_W-1:0]    m0_arqos,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [ID_W-1:0]     m0_awid,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [LEN_W-1:0]    m0_awlen,
    input  logic [SIZE_W-1:0]   m0_awsize,
    input  logic [BURST_W-1:0]  m0_awburst,
    input  logic [LOCK_W-1:0]   m0_awlock,
    input  logic [CACHE_W-1:0]  m0_awcache,
    input  logic [PROT_W-1:0]   m0_awprot,
    input  logic [QOS_W-1:0]    m0_awqos,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wlast,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [ID_W-1:0]     m0_rid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [RESP_W-1:0]   m0_rresp,
    output logic                m0_rlast,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    output logic [ID_W-1:0]     m0_bid,
    output logic [RESP_W-1:0]   m0_bresp,
    // master 1
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ID_W-1:0]     m1_arid,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [LEN_W-1:0]    m1_arlen,
    input  logic [SIZE_W-1:0]   m1_arsize,
    input  logic [BURST_W-1:0]  m1_arburst,
    input  logic [LOCK_W-1:0]   m1_arlock,
    input  logic [CACHE_W-1:0]  m1_arcache,
    input  logic [PROT_W-1:0]   m1_arprot,
    input  logic [QOS_W-1:0]    m1_arqos,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [LEN_W-1:0]    m1_awlen,
    input  logic [SIZE_W-1:0]   m1_awsize,
    input  logic [BURST_W-1:0]  m1_awburst,
    input  logic [LOCK_W-1:0]   m1_awlock,
    input  logic [CACHE_W-1:0]  m1_awcache,
    input  logic [PROT_W-1:0]   m1_awprot,
    input  logic [QOS_W-1:0]    m1_awqos,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [ID_W-1:0]     m1_rid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [RESP_W-1:0]   m1_rresp,
    output logic                m1_rlast,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ID_W-1:0]     m1_bid,
    output logic [RESP_W-1:0]   m1_bresp,
    // slave
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ID_W:0]       s_arid,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [LEN_W-1:0]    s_arlen,
    output logic [SIZE_W-1:0]   s_arsize,
    output logic [BURST_W-1:0]  s_arburst,
    output logic [LOCK_W-1:0]   s_arlock,
    output logic [CACHE_W-1:0]  s_arcache,
    output logic [PROT_W-1:0]   s_arprot,
    output logic [QOS_W-1:0]    s_arqos,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ID_W:0]       s_awid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [LEN_W-1:0]    s_awlen,
    output logic [SIZE_W-1:0]   s_awsize,
    output logic [BURST_W-1:0]  s_awburst,
    output logic [LOCK_W-1:0]   s_awlock,
    output logic [CACHE_W-1:0]  s_awcache,
    output logic [PROT_W-1:0]   s_awprot,
    output logic [QOS_W-1:0]    s_awqos,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [ID_W:0]       s_rid,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [RESP_W-1:0]   s_rresp,
    input  logic                s_rlast,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [ID_W:0]       s_bid,
    input  logic [RESP_W-1:0]   s_bresp
);
    mst_idx_t ar_ptr, ar_gnt_q, ar_gnt;
    mst_idx_t aw_ptr, aw_gnt_q, aw_gnt;
    logic     ar_lock, aw_lock;
    logic     ar_hs, aw_hs, w_pop;
    mst_idx_t wq_head;
    logic     wq_full, wq_empty;

    // AR channel: grant is held from the first un-accepted cycle until the handshake
    assign ar_gnt     = ar_lock ? ar_gnt_q : rr_pick(ar_ptr, m0_arvalid, m1_arvalid);
    assign s_arvalid  = !reset && (ar_gnt ? m1_arvalid : m0_arvalid);
    assign ar_hs      = s_arvalid && s_arready;
    assign m0_arready = ar_hs && !ar_gnt;
    assign m1_arready = ar_hs && ar_gnt;
    assign s_arid     = {ar_gnt, ar_gnt ? m1_arid : m0_arid};
    assign s_araddr   = ar_gnt ? m1_araddr  : m0_araddr;
    assign s_arlen    = ar_gnt ? m1_arlen   : m0_arlen;
    assign s_arsize   = ar_gnt ? m1_arsize  : m0_arsize;
    assign s_arburst  = ar_gnt ? m1_arburst : m0_arburst;
    assign s_arlock   = ar_gnt ? m1_arlock  : m0_arlock;
    assign s_arcache  = ar_gnt ? m1_arcache : m0_arcache;
    assign s_arprot   = ar_gnt ? m1_arprot  : m0_arprot;
    assign s_arqos    = ar_gnt ? m1_arqos   : m0_arqos;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ar_lock  <= 1'b0;
            ar_gnt_q <= 1'b0;
            ar_ptr   <= 1'b0;
        end else if (ar_hs) begin
            ar_lock  <= 1'b0;
            ar_ptr   <= rr_next(ar_gnt);
        end else if (s_arvalid) begin
            ar_lock  <= 1'b1;
            ar_gnt_q <= ar_gnt;
        end
    end

    // AW channel: same scheme, but nothing is offered while the order FIFO is full
    assign aw_gnt     = aw_lock ? aw_gnt_q : rr_pick(aw_ptr, m0_awvalid, m1_awvalid);
    assign s_awvalid  = !reset && !wq_full && (aw_gnt ? m1_awvalid : m0_awvalid);
    assign aw_hs      = s_awvalid && s_awready;
    assign m0_awready = aw_hs && !aw_gnt;
    assign m1_awready = aw_hs && aw_gnt;
    assign s_awid     = {aw_gnt, aw_gnt ? m1_awid : m0_awid};
    assign s_awaddr   = aw_gnt ? m1_awaddr  : m0_awaddr;
    assign s_awlen    = aw_gnt ? m1_awlen   : m0_awlen;
    assign s_awsize   = aw_gnt ? m1_awsize  : m0_awsize;
    assign s_awburst  = aw_gnt ? m1_awburst : m0_awburst;
    assign s_awlock   = aw_gnt ? m1_awlock  : m0_awlock;
    assign s_awcache  = aw_gnt ? m1_awcache : m0_awcache;
    assign s_awprot   = aw_gnt ? m1_awprot  : m0_awprot;
    assign s_awqos    = aw_gnt ? m1_awqos   : m0_awqos;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aw_lock  <= 1'b0;
            aw_gnt_q <= 1'b0;
            aw_ptr   <= 1'b0;
        end else if (aw_hs) begin
            aw_lock  <= 1'b0;
            aw_ptr   <= rr_next(aw_gnt);
        end else if (s_awvalid) begin
            aw_lock  <= 1'b1;
            aw_gnt_q <= aw_gnt;
        end
    end

    axi_wr_order_fifo #(.WQ_DEPTH(WQ_DEPTH)) u_wq (
        .clock    (clock),
        .reset    (reset),
        .push     (aw_hs),
        .push_idx (aw_gnt),
        .pop      (w_pop),
        .head_idx (wq_head),
        .full     (wq_full),
        .empty    (wq_empty)
    );

    // W channel belongs to the master at the FIFO head until its wlast is accepted
    assign s_wvalid  = !wq_empty && (wq_head ? m1_wvalid : m0_wvalid);
    assign s_wdata   = wq_head ? m1_wdata : m0_wdata;
    assign s_wstrb   = wq_head ? m1_wstrb : m0_wstrb;
    assign s_wlast   = wq_head ? m1_wlast : m0_wlast;
    assign m0_wready = !wq_empty && !wq_head && s_wready;
    assign m1_wready = !wq_empty && wq_head && s_wready;
    assign w_pop     = s_wvalid && s_wready && s_wlast;

    // R/B return: the ID MSB names the master
    assign m0_rvalid = !reset && s_rvalid && !s_rid[ID_W];
    assign m1_rvalid = !reset && s_rvalid && s_rid[ID_W];
    assign s_rready  = !reset && (s_rid[ID_W] ? m1_rready : m0_rready);
    assign m0_rid    = s_rid[ID_W-1:0];
    assign m1_rid    = s_rid[ID_W-1:0];
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m1_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m1_rlast  = s_rlast;

    assign m0_bvalid = !reset && s_bvalid && !s_bid[ID_W];
    assign m1_bvalid = !reset && s_bvalid && s_bid[ID_W];
    assign s_bready  = !reset && (s_bid[ID_W] ? m1_bready : m0_bready);
    assign m0_bid    = s_bid[ID_W-1:0];
    assign m1_bid    = s_bid[ID_W-1:0];
    assign m0_bresp  = s_bresp;
    assign m1_bresp  = s_bresp;
endmodule

// File: tb/tb_ddr_axi_arbiter.sv
// Directed bench for ddr_axi_arbiter: R/B routing table plus AR/AW/W/reset sequences.
module tb_ddr_axi_arbiter;
    logic clock, reset;
    logic m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [3:0] m0_arid, m1_arid;
    logic [33:0] m0_araddr, m1_araddr;
    logic [7:0] m0_arlen, m1_arlen;
    logic [2:0] m0_arsize, m1_arsize;
    logic [1:0] m0_arburst, m1_arburst;
    logic m0_arlock, m1_arlock;
    logic [3:0] m0_arcache, m1_arcache;
    logic [2:0] m0_arprot, m1_arprot;
    logic [3:0] m0_arqos, m1_arqos;
    logic m0_awvalid, m0_awready, m1_awvalid, m1_awready;
    logic [3:0] m0_awid, m1_awid;
    logic [33:0] m0_awaddr, m1_awaddr;
    logic [7:0] m0_awlen, m1_awlen;
    logic [2:0] m0_awsize, m1_awsize;
    logic [1:0] m0_awburst, m1_awburst;
    logic m0_awlock, m1_awlock;
    logic [3:0] m0_awcache, m1_awcache;
    logic [2:0] m0_awprot, m1_awprot;
    logic [3:0] m0_awqos, m1_awqos;
    logic m0_wvalid, m0_wready, m1_wvalid, m1_wready, m0_wlast, m1_wlast;
    logic [63:0] m0_wdata, m1_wdata;
    logic [7:0] m0_wstrb, m1_wstrb;
    logic m0_rvalid, m0_rready, m1_rvalid, m1_rready, m0_rlast, m1_rlast;
    logic [3:0] m0_rid, m1_rid;
    logic [63:0] m0_rdata, m1_rdata;
    logic [1:0] m0_rresp, m1_rresp;
    logic m0_bvalid, m0_bready, m1_bvalid, m1_bready;
    logic [3:0] m0_bid, m1_bid;
    logic [1:0] m0_bresp, m1_bresp;
    logic s_arvalid, s_arready, s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
    logic [4:0] s_arid, s_awid, s_rid, s_bid;
    logic [33:0] s_araddr, s_awaddr;
    logic [7:0] s_arlen, s_awlen, s_wstrb;
    logic [2:0] s_arsize, s_awsize, s_arprot, s_awprot;
    logic [1:0] s_arburst, s_awburst, s_rresp, s_bresp;
    logic s_arlock, s_awlock;
    logic [3:0] s_arcache, s_awcache, s_arqos, s_awqos;
    logic [63:0] s_wdata, s_rdata;
    logic s_rvalid, s_rready, s_rlast, s_bvalid, s_bready;

    int checks = 0;
    int errors = 0;

    ddr_axi_arbiter #(.ID_W(4), .ADDR_W(34), .DATA_W(64), .WQ_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid), .m0_araddr(m0_araddr),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arlock(m0_arlock),
        .m0_arcache(m0_arcache), .m0_arprot(m0_arprot), .m0_arqos(m0_arqos),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awid(m0_awid), .m0_awaddr(m0_awaddr),
        .m0_awlen(m0_awlen), .m0_awsize(m0_awsize), .m0_awburst(m0_awburst), .m0_awlock(m0_awlock),
        .m0_awcache(m0_awcache), .m0_awprot(m0_awprot), .m0_awqos(m0_awqos),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_wlast(m0_wlast),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rid(m0_rid), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bid(m0_bid), .m0_bresp(m0_bresp),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid), .m1_araddr(m1_araddr),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arlock(m1_arlock),
        .m1_arcache(m1_arcache), .m1_arprot(m1_arprot), .m1_arqos(m1_arqos),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awid(m1_awid), .m1_awaddr(m1_awaddr),
        .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awlock(m1_awlock),
        .m1_awcache(m1_awcache), .m1_awprot(m1_awprot), .m1_awqos(m1_awqos),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_wlast(m1_wlast),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rid(m1_rid), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bid(m1_bid), .m1_bresp(m1_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock),
        .s_arcache(s_arcache), .s_arprot(s_arprot), .s_arqos(s_arqos),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awlock(s_awlock),
        .s_awcache(s_awcache), .s_awprot(s_awprot), .s_awqos(s_awqos),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rv;
        logic [4:0] rid;
        logic       r0rdy;
        logic       r1rdy;
        logic       bv;
        logic [4:0] bid;
        logic       b0rdy;
        logic       b1rdy;
        logic       e_m0rv;
        logic       e_m1rv;
        logic [3:0] e_rid;
        logic       e_srrdy;
        logic       e_m0bv;
        logic       e_m1bv;
        logic [3:0] e_bid;
        logic       e_sbrdy;
    } rb_vec_t;

    rb_vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        {m0_arvalid, m0_arid, m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_arlock, m0_arcache, m0_arprot, m0_arqos} = '0;
        {m1_arvalid, m1_arid, m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_arlock, m1_arcache, m1_arprot, m1_arqos} = '0;
        {m0_awvalid, m0_awid, m0_awaddr, m0_awlen, m0_awsize, m0_awburst, m0_awlock, m0_awcache, m0_awprot, m0_awqos} = '0;
        {m1_awvalid, m1_awid, m1_awaddr, m1_awlen, m1_awsize, m1_awburst, m1_awlock, m1_awcache, m1_awprot, m1_awqos} = '0;
        {m0_wvalid, m0_wdata, m0_wstrb, m0_wlast, m1_wvalid, m1_wdata, m1_wstrb, m1_wlast} = '0;
        {m0_rready, m1_rready, m0_bready, m1_bready} = '0;
        {s_arready, s_awready, s_wready} = '0;
        {s_rvalid, s_rid, s_rdata, s_rresp, s_rlast, s_bvalid, s_bid, s_bresp} = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'h03, 1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
        vecs[1] = '{1'b1, 5'h13, 1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
        vecs[2] = '{1'b1, 5'h1A, 1'b0, 1'b1, 1'b1, 5'h07, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 4'h7, 1'b0};
        vecs[3] = '{1'b0, 5'h0F, 1'b1, 1'b1, 1'b1, 5'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 4'hC, 1'b1};
        vecs[4] = '{1'b1, 5'h05, 1'b0, 1'b1, 1'b1, 5'h19, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 4'h9, 1'b0};
        vecs[5] = '{1'b0, 5'h10, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};

        clear_inputs();
        reset = 1'b1;
        m0_arvalid = 1'b1; m1_awvalid = 1'b1; s_rvalid = 1'b1; s_bvalid = 1'b1;
        m0_rready = 1'b1; m0_bready = 1'b1; m0_wvalid = 1'b1; s_wready = 1'b1;
        s_arready = 1'b1; s_awready = 1'b1;
        #3;
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_awvalid", s_awvalid, 0);
        chk("rst_m0_arready", m0_arready, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m0_bvalid", m0_bvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_m0_wready", m0_wready, 0);
        chk("rst_s_wvalid", s_wvalid, 0);
        step();
        step();
        do_reset();

        // R/B routing table
        for (int i = 0; i < 6; i++) begin
            s_rvalid = vecs[i].rv; s_rid = vecs[i].rid;
            m0_rready = vecs[i].r0rdy; m1_rready = vecs[i].r1rdy;
            s_bvalid = vecs[i].bv; s_bid = vecs[i].bid;
            m0_bready = vecs[i].b0rdy; m1_bready = vecs[i].b1rdy;
            s_rdata = 64'hA5A5_0000_0000_0000 | 64'(i);
            settle();
            chk($sformatf("v%0d_m0_rvalid", i), m0_rvalid, vecs[i].e_m0rv);
            chk($sformatf("v%0d_m1_rvalid", i), m1_rvalid, vecs[i].e_m1rv);
            chk($sformatf("v%0d_rid", i), vecs[i].rid[4] ? m1_rid : m0_rid, vecs[i].e_rid);
            chk($sformatf("v%0d_rdata", i), vecs[i].rid[4] ? m1_rdata : m0_rdata, 64'hA5A5_0000_0000_0000 | 64'(i));
            chk($sformatf("v%0d_s_rready", i), s_rready, vecs[i].e_srrdy);
            chk($sformatf("v%0d_m0_bvalid", i), m0_bvalid, vecs[i].e_m0bv);
            chk($sformatf("v%0d_m1_bvalid", i), m1_bvalid, vecs[i].e_m1bv);
            chk($sformatf("v%0d_bid", i), vecs[i].bid[4] ? m1_bid : m0_bid, vecs[i].e_bid);
            chk($sformatf("v%0d_s_bready", i), s_bready, vecs[i].e_sbrdy);
            step();
        end
        clear_inputs();

        // single m0 read, then its response
        m0_arvalid = 1'b1; m0_arid = 4'h3; m0_araddr = 34'h1000; s_arready = 1'b1;
        settle();
        chk("t1_s_arvalid", s_arvalid, 1);
        chk("t1_s_arid", s_arid, 5'h03);
        chk("t1_s_araddr", s_araddr, 34'h1000);
        chk("t1_m0_arready", m0_arready, 1);
        chk("t1_m1_arready", m1_arready, 0);
        step();
        clear_inputs();
        s_rvalid = 1'b1; s_rid = 5'h03; m0_rready = 1'b1;
        settle();
        chk("t1_m0_rvalid", m0_rvalid, 1);
        chk("t1_m1_rvalid", m1_rvalid, 0);
        chk("t1_m0_rid", m0_rid, 4'h3);
        step();

        // both masters read every cycle: alternating grants
        do_reset();
        m0_arvalid = 1'b1; m0_arid = 4'h2; m0_araddr = 34'h100;
        m1_arvalid = 1'b1; m1_arid = 4'h5; m1_araddr = 34'h200;
        s_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("t2_s_arid_%0d", i), s_arid, (i % 2) ? 5'h15 : 5'h02);
            chk($sformatf("t2_s_araddr_%0d", i), s_araddr, (i % 2) ? 34'h200 : 34'h100);
            chk($sformatf("t2_m1_arready_%0d", i), m1_arready, (i % 2) ? 1 : 0);
            chk($sformatf("t2_m0_arready_%0d", i), m0_arready, (i % 2) ? 0 : 1);
            step();
        end

        // grant locked while slave stalls, even though the pointer favours m1
        do_reset();
        m0_arvalid = 1'b1; s_arready = 1'b1;
        step();
        m0_arid = 4'h1; m0_araddr = 34'h2000; s_arready = 1'b0;
        m1_arid = 4'h6; m1_araddr = 34'h3000;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) m1_arvalid = 1'b1;
            settle();
            chk($sformatf("t3_s_arvalid_%0d", c), s_arvalid, 1);
            chk($sformatf("t3_s_arid_%0d", c), s_arid, 5'h01);
            chk($sformatf("t3_s_araddr_%0d", c), s_araddr, 34'h2000);
            chk($sformatf("t3_m1_arready_%0d", c), m1_arready, 0);
            step();
        end
        s_arready = 1'b1;
        settle();
        chk("t3_m0_arready", m0_arready, 1);
        step();
        m0_arvalid = 1'b0;
        settle();
        chk("t3_after_s_arid", s_arid, 5'h16);
        chk("t3_after_m1_arready", m1_arready, 1);
        step();

        // W ordering: m1 AW first, m0 W waits for m1 wlast
        do_reset();
        s_awready = 1'b1; s_wready = 1'b1;
        m1_awvalid = 1'b1; m1_awid = 4'h2; m1_awlen = 8'd3;
        m0_wvalid = 1'b1; m0_wdata = 64'hDEAD_BEEF_0000_0000; m0_wlast = 1'b1; m0_wstrb = 8'hFF;
        settle();
        chk("t4_s_awid_m1", s_awid, 5'h12);
        chk("t4_s_awlen_m1", s_awlen, 8'd3);
        chk("t4_m0_wready_empty", m0_wready, 0);
        chk("t4_s_wvalid_empty", s_wvalid, 0);
        step();
        m1_awvalid = 1'b0;
        m0_awvalid = 1'b1; m0_awid = 4'h4; m0_awlen = 8'd0;
        for (int b = 0; b < 4; b++) begin
            m1_wvalid = 1'b1; m1_wdata = 64'h1111_0000_0000_0000 | 64'(b); m1_wlast = (b == 3);
            m1_wstrb = 8'h0F;
            settle();
            if (b == 0) chk("t4_s_awid_m0", s_awid, 5'h04);
            chk($sformatf("t4_m0_wready_b%0d", b), m0_wready, 0);
            chk($sformatf("t4_m1_wready_b%0d", b), m1_wready, 1);
            chk($sformatf("t4_s_wdata_b%0d", b), s_wdata, 64'h1111_0000_0000_0000 | 64'(b));
            chk($sformatf("t4_s_wlast_b%0d", b), s_wlast, (b == 3) ? 1 : 0);
            step();
            m0_awvalid = 1'b0;
        end
        m1_wvalid = 1'b0; m1_wlast = 1'b0;
        settle();
        chk("t4_m0_wready_turn", m0_wready, 1);
        chk("t4_m1_wready_turn", m1_wready, 0);
        chk("t4_s_wdata_m0", s_wdata, 64'hDEAD_BEEF_0000_0000);
        chk("t4_s_wstrb_m0", s_wstrb, 8'hFF);
        step();
        m0_wvalid = 1'b0;
        settle();
        chk("t4_s_wvalid_drained", s_wvalid, 0);
        step();

        // order FIFO full blocks AW, with no same-cycle bypass
        do_reset();
        s_awready = 1'b1;
        m0_awvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m0_awid = 4'(i);
            settle();
            chk($sformatf("t5_awready_%0d", i), m0_awready, 1);
            step();
        end
        m0_awid = 4'h9;
        settle();
        chk("t5_full_awready", m0_awready, 0);
        chk("t5_full_s_awvalid", s_awvalid, 0);
        m0_wvalid = 1'b1; m0_wlast = 1'b1; s_wready = 1'b1;
        settle();
        chk("t5_pop_m0_wready", m0_wready, 1);
        chk("t5_nobypass_awready", m0_awready, 0);
        step();
        m0_wvalid = 1'b0;
        settle();
        chk("t5_after_pop_awready", m0_awready, 1);
        chk("t5_after_pop_s_awid", s_awid, 5'h09);
        step();

        // reset mid W burst
        do_reset();
        s_awready = 1'b1; s_wready = 1'b1;
        m0_awvalid = 1'b1; m0_awlen = 8'd1;
        step();
        m0_awvalid = 1'b0;
        m0_wvalid = 1'b1; m0_wlast = 1'b0;
        settle();
        chk("t6_beat1_wready", m0_wready, 1);
        step();
        m0_wlast = 1'b1;
        m0_arvalid = 1'b1; s_arready = 1'b1;
        s_rvalid = 1'b1; m0_rready = 1'b1; s_bvalid = 1'b1; m0_bready = 1'b1;
        settle();
        chk("t6_beat2_s_wvalid", s_wvalid, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_s_wvalid", s_wvalid, 0);
        chk("t6_rst_m0_wready", m0_wready, 0);
        chk("t6_rst_s_arvalid", s_arvalid, 0);
        chk("t6_rst_m0_arready", m0_arready, 0);
        chk("t6_rst_m0_rvalid", m0_rvalid, 0);
        chk("t6_rst_s_rready", s_rready, 0);
        chk("t6_rst_m0_bvalid", m0_bvalid, 0);
        clear_inputs();
        step();
        reset = 1'b0;
        #1;
        m0_wvalid = 1'b1; s_wready = 1'b1;
        m0_arvalid = 1'b1; m0_arid = 4'h7; m1_arvalid = 1'b1; m1_arid = 4'h9;
        settle();
        chk("t6_post_s_wvalid", s_wvalid, 0);
        chk("t6_post_m0_wready", m0_wready, 0);
        chk("t6_post_s_arid", s_arid, 5'h07);
        step();
        clear_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
